// File: rtl/saltflower_breath_pkg.sv
// Shared types for the helical NAND array breath pipeline.
// Holds the collector FSM encoding, the breath record layout and a popcount helper.
package saltflower_breath_pkg;

    localparam int CELL_COUNT  = 8;
    localparam int REM_COUNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        ARMED,
        CAPTURE,
        WAIT
    } collector_state_t;

    typedef struct packed {
        logic [CELL_COUNT-1:0]  data;
        logic [CELL_COUNT-1:0]  rem;
        logic [REM_COUNT_W-1:0] rem_count;
        logic                   violation;
    } breath_record_t;

    function automatic logic [REM_COUNT_W-1:0] popcount(
        input logic [CELL_COUNT-1:0] v
    );
        logic [REM_COUNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < CELL_COUNT; i++) begin
            n = n + {{(REM_COUNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/breath_record_fifo.sv
// First-word fall-through FIFO of breath records.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module breath_record_fifo
    import saltflower_breath_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  breath_record_t din,
    input  logic           pop,
    output breath_record_t dout,
    output logic           push_ok,
    output logic           full,
    output logic           empty,
    output logic [LW-1:0]  level
);

    breath_record_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  count;
    logic           pop_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign level   = count;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(push_ok) - LW'(pop_ok);
        end
    end

    // Record storage; contents are only visible while non-empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/breath_remainder_collector.sv
// Captures one record per breath from the NAND array and streams it out.
// Optional COLLECTOR_STATS_EN adds saturating breath/violation counters.
module breath_remainder_collector
    import saltflower_breath_pkg::*;
#(
    parameter  int DEPTH      = 4,
    parameter  bit AUTO_REARM = 1'b1,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [CELL_COUNT-1:0]  arr_data,
    input  logic [CELL_COUNT-1:0]  arr_remainders,
    input  logic                   arr_violation,
    input  logic                   arr_breath_complete,
    output logic                   start_breath,
    input  logic                   rearm_req,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CELL_COUNT-1:0]  out_data,
    output logic [CELL_COUNT-1:0]  out_remainders,
    output logic [REM_COUNT_W-1:0] out_rem_count,
    output logic                   out_violation,
    output logic                   overflow,
    input  logic                   clr_overflow,
    output logic [LW-1:0]          level
`ifdef COLLECTOR_STATS_EN
    ,
    output logic [15:0]            breath_count,
    output logic [15:0]            violation_count
`endif
);

    collector_state_t state;
    collector_state_t state_nxt;
    logic             bc_prev;
    logic             window;
    logic             capture;
    logic             pop;
    logic             push_ok;
    logic             full;
    logic             empty;
    logic             full_after;
    logic [LW-1:0]    lvl_next;
    breath_record_t   rec;
    breath_record_t   head;

    assign capture = (state == CAPTURE);
    assign pop     = out_valid & out_ready;

    assign rec.data      = arr_data;
    assign rec.rem       = arr_remainders;
    assign rec.rem_count = popcount(arr_remainders);
    assign rec.violation = window | arr_violation;

    assign lvl_next   = level + LW'(push_ok) - LW'(pop);
    assign full_after = (lvl_next == LW'(DEPTH));

    breath_record_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (capture),
        .din     (rec),
        .pop     (pop),
        .dout    (head),
        .push_ok (push_ok),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign out_valid      = ~empty;
    assign out_data       = head.data;
    assign out_remainders = head.rem;
    assign out_rem_count  = head.rem_count;
    assign out_violation  = head.violation;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state; a CAPTURE still pushes even when enable drops.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable) state_nxt = KICK;
            KICK:    state_nxt = ARMED;
            ARMED:   if (arr_breath_complete && !bc_prev) state_nxt = CAPTURE;
            CAPTURE: state_nxt = (AUTO_REARM && !full_after) ? KICK : WAIT;
            WAIT:    if ((AUTO_REARM && !full) || rearm_req) state_nxt = KICK;
            default: state_nxt = IDLE;
        endcase
        if (!enable) state_nxt = IDLE;
    end

    // FSM outputs.
    always_comb begin
        start_breath = 1'b0;
        if (state == KICK) start_breath = 1'b1;
    end

    // Breath-complete edge history and per-breath violation window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_prev <= 1'b0;
            window  <= 1'b0;
        end else begin
            bc_prev <= arr_breath_complete;
            if (state == KICK)       window <= 1'b0;
            else if (state == ARMED) window <= window | arr_violation;
        end
    end

    // Sticky overflow; a dropped capture wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  overflow <= 1'b0;
        else if (capture && !push_ok) overflow <= 1'b1;
        else if (clr_overflow)        overflow <= 1'b0;
    end

`ifdef COLLECTOR_STATS_EN
    // Saturating capture statistics, dropped captures included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            breath_count    <= '0;
            violation_count <= '0;
        end else if (clr_overflow) begin
            breath_count    <= '0;
            violation_count <= '0;
        end else if (capture) begin
            if (breath_count != 16'hFFFF)
                breath_count <= breath_count + 16'd1;
            if (rec.violation && violation_count != 16'hFFFF)
                violation_count <= violation_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_breath_remainder_collector.sv
// Randomised self-checking bench for breath_remainder_collector.
// A queue-based reference model tracks expected records and overflow.
module tb_breath_remainder_collector;

    localparam int DEPTH      = 4;
    localparam bit AUTO_REARM = 1'b1;
    localparam int LW         = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [7:0]    arr_data = '0;
    logic [7:0]    arr_remainders = '0;
    logic          arr_violation = 1'b0;
    logic          arr_breath_complete = 1'b0;
    logic          rearm_req = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          start_breath;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [7:0]    out_remainders;
    logic [3:0]    out_rem_count;
    logic          out_violation;
    logic          overflow;
    logic [LW-1:0] level;
`ifdef COLLECTOR_STATS_EN
    logic [15:0]   breath_count;
    logic [15:0]   violation_count;
`endif

    breath_remainder_collector #(.DEPTH(DEPTH), .AUTO_REARM(AUTO_REARM)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .arr_data            (arr_data),
        .arr_remainders      (arr_remainders),
        .arr_violation       (arr_violation),
        .arr_breath_complete (arr_breath_complete),
        .start_breath        (start_breath),
        .rearm_req           (rearm_req),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_remainders      (out_remainders),
        .out_rem_count       (out_rem_count),
        .out_violation       (out_violation),
        .overflow            (overflow),
        .clr_overflow        (clr_overflow),
        .level               (level)
`ifdef COLLECTOR_STATS_EN
        ,
        .breath_count        (breath_count),
        .violation_count     (violation_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [7:0] r;
        bit         v;
    } exp_t;

    exp_t q[$];
    bit   ovf_m;
    int   brc_m;
    int   vc_m;
    int   errors;
    int   checks;

    function automatic logic [20:0] pack(input exp_t e);
        return {e.d, e.r, 4'($countones(e.r)), e.v};
    endfunction

    task automatic do_breath(input logic [7:0] d, input logic [7:0] r,
                             input bit v, input int hold, input bit rdy);
        exp_t        e;
        bit          popped;
        logic [20:0] got;
        @(negedge clk);
        arr_violation = v;
        @(negedge clk);
        arr_violation = 1'b0;
        @(negedge clk);
        arr_data = d;
        arr_remainders = r;
        arr_breath_complete = 1'b1;
        @(negedge clk);
        if (hold <= 1) arr_breath_complete = 1'b0;
        popped = rdy && (q.size() > 0);
        if (popped) begin
            checks++;
            got = {out_data, out_remainders, out_rem_count, out_violation};
            if (got !== pack(q[0])) begin
                errors++;
                $display("FAIL cap_pop_head: got %h want %h", got, pack(q[0]));
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        e.d = d;
        e.r = r;
        e.v = v;
        brc_m++;
        if (v) vc_m++;
        if (q.size() < DEPTH || popped) begin
            if (popped) void'(q.pop_front());
            q.push_back(e);
        end else begin
            ovf_m = 1'b1;
        end
        checks++;
        if (level !== LW'(q.size())) begin
            errors++;
            $display("FAIL cap_level: got %0d want %0d", level, q.size());
        end
        checks++;
        if (overflow !== ovf_m) begin
            errors++;
            $display("FAIL cap_overflow: got %0b want %0b", overflow, ovf_m);
        end
        checks++;
        if (start_breath !== (AUTO_REARM && q.size() < DEPTH)) begin
            errors++;
            $display("FAIL cap_rearm: got %0b want %0b", start_breath,
                     (AUTO_REARM && q.size() < DEPTH));
        end
        for (int i = 2; i < hold; i++) @(negedge clk);
        arr_breath_complete = 1'b0;
        if (hold > 2) begin
            @(negedge clk);
            checks++;
            if (level !== LW'(q.size())) begin
                errors++;
                $display("FAIL hold_level: got %0d want %0d", level, q.size());
            end
        end
    endtask

    task automatic drain();
        logic [20:0] got;
        while (q.size() > 0) begin
            checks++;
            got = {out_data, out_remainders, out_rem_count, out_violation};
            if (out_valid !== 1'b1 || got !== pack(q[0])) begin
                errors++;
                $display("FAIL drain_head: got v=%0b %h want %h",
                         out_valid, got, pack(q[0]));
            end
            out_ready = 1'b1;
            @(negedge clk);
            void'(q.pop_front());
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || level !== '0) begin
            errors++;
            $display("FAIL drain_empty: got v=%0b lvl=%0d want 0 0",
                     out_valid, level);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        #12;
        checks++;
        if ({start_breath, out_valid, out_data, out_remainders, out_rem_count,
             out_violation, overflow, level} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero want 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (start_breath !== 1'b1) begin
            errors++;
            $display("FAIL first_kick: got %0b want 1", start_breath);
        end
        @(negedge clk);
        checks++;
        if (start_breath !== 1'b0) begin
            errors++;
            $display("FAIL kick_width: got %0b want 0", start_breath);
        end
    endtask

    task automatic test_basic();
        do_breath(8'hA5, 8'h0F, 1'b0, 1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_rem_count !== 4'd4
            || out_violation !== 1'b0) begin
            errors++;
            $display("FAIL basic_record: got v=%0b d=%h c=%0d x=%0b want 1 a5 4 0",
                     out_valid, out_data, out_rem_count, out_violation);
        end
        drain();
    endtask

    task automatic test_violation();
        do_breath(8'h3C, 8'hFF, 1'b1, 1, 1'b0);
        do_breath(8'hC3, 8'h00, 1'b0, 1, 1'b0);
        drain();
    endtask

    task automatic test_hold();
        do_breath(8'h5A, 8'h81, 1'b0, 5, 1'b0);
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++)
                do_breath(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                          $urandom_range(1, 3), 1'b0);
            drain();
        end
    endtask

    task automatic test_full();
        logic [20:0] got;
        for (int j = 0; j < DEPTH; j++)
            do_breath(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                      1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            got = {out_data, out_remainders, out_rem_count, out_violation};
            if (start_breath !== 1'b0 || level !== LW'(DEPTH)
                || got !== pack(q[0])) begin
                errors++;
                $display("FAIL wait_idle: got sb=%0b lvl=%0d %h want 0 4 %h",
                         start_breath, level, got, pack(q[0]));
            end
        end
        @(negedge clk);
        rearm_req = 1'b1;
        @(negedge clk);
        rearm_req = 1'b0;
        checks++;
        if (start_breath !== 1'b1) begin
            errors++;
            $display("FAIL manual_rearm: got %0b want 1", start_breath);
        end
        do_breath(8'hEE, 8'hF0, 1'b1, 1, 1'b0);
        @(negedge clk);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        ovf_m = 1'b0;
        brc_m = 0;
        vc_m = 0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_overflow: got %0b want 0", overflow);
        end
        @(negedge clk);
        rearm_req = 1'b1;
        @(negedge clk);
        rearm_req = 1'b0;
        do_breath(8'h77, 8'hFF, 1'b1, 1, 1'b1);
`ifdef COLLECTOR_STATS_EN
        checks++;
        if (breath_count !== 16'(brc_m) || violation_count !== 16'(vc_m)) begin
            errors++;
            $display("FAIL stats: got %0d %0d want %0d %0d",
                     breath_count, violation_count, brc_m, vc_m);
        end
`endif
        drain();
    endtask

    task automatic test_async_reset();
        do_breath(8'h11, 8'h07, 1'b0, 1, 1'b0);
        do_breath(8'h22, 8'h70, 1'b1, 1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start_breath, out_valid, out_data, out_remainders, out_rem_count,
             out_violation, overflow, level} !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%0b lvl=%0d want 0 0",
                     out_valid, level);
        end
        q.delete();
        ovf_m = 1'b0;
        brc_m = 0;
        vc_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (start_breath !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_kick: got %0b want 1", start_breath);
        end
        do_breath(8'h99, 8'h01, 1'b0, 2, 1'b0);
        drain();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ovf_m  = 1'b0;
        brc_m  = 0;
        vc_m   = 0;
        test_reset();
        test_basic();
        test_violation();
        test_hold();
        test_random();
        test_full();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
